uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx2 transmitter among N byte-stream requesters. Round-robin

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx2 arbiter: FSM state encoding and
// character constants used by uart_tx2 clients.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

    localparam logic [7:0] ASCII_NL = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// wrapping at N-1. Emits the winner both one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] index,
    output logic          any
);

    logic found;

    // First pass covers ptr..N-1, second pass the wrapped range 0..ptr-1.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && valid[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                index    = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                index    = PW'(i);
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx2 among N byte-stream requesters. A round-robin winner
// keeps the UART until LAST, the burst limit, or a stall timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N            = 4,
    parameter int MAX_BURST    = 64,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_byte,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           tx_dv,
    output logic [7:0]     tx_byte,
    input  logic           tx_done,
    output logic           busy
);

    localparam int PW = $clog2(N);
    localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [7:0]    BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [TW-1:0] HOLD_LIMIT  = TW'(HOLD_TIMEOUT - 1);

    arb_state_t    state, state_next;
    logic [PW-1:0] ptr, owner, pick_index;
    logic [N-1:0]  pick_grant;
    logic          pick_any;
    logic [7:0]    burst;
    logic [TW-1:0] hold_cnt;
    logic          last_flag, owner_valid, release_lock;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    assign owner_valid = req_valid[owner];
    assign req_ready   = (state == ST_LOAD) ? grant : '0;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // While locked, only the owner's VALID matters; other requesters wait.
    always_comb begin
        state_next   = state;
        release_lock = 1'b0;
        unique case (state)
            ST_IDLE: if (pick_any) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (last_flag || (burst == BURST_LIMIT)) begin
                        release_lock = 1'b1;
                        state_next   = ST_IDLE;
                    end else if (owner_valid) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (owner_valid) begin
                    state_next = ST_LOAD;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    release_lock = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            owner     <= '0;
            ptr       <= '0;
            burst     <= '0;
            hold_cnt  <= '0;
            last_flag <= 1'b0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_grant;
                        owner <= pick_index;
                        burst <= '0;
                    end
                end
                // TX_DV is registered so TX_BYTE is already valid when uart_tx2 samples it.
                ST_LOAD: begin
                    tx_dv     <= 1'b1;
                    tx_byte   <= req_byte[{owner, 3'b000} +: 8];
                    last_flag <= req_last[owner];
                    burst     <= burst + 8'd1;
                end
                ST_WAIT: if (state_next == ST_HOLD) hold_cnt <= '0;
                ST_HOLD: hold_cnt <= hold_cnt + TW'(1);
                default: ;
            endcase
            if (release_lock) begin
                grant <= '0;
                ptr   <= (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart_tx2 timing model and a
// scoreboard of expected (grant, byte) pairs popped on every TX_DV.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N            = 4;
    localparam int MAX_BURST    = 4;
    localparam int HOLD_TIMEOUT = 16;
    localparam int BIT_CLKS     = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_dv;
    logic [7:0]     tx_byte;
    logic           tx_done;
    logic           busy;
    logic           model_done = 1'b0;
    logic           spur_done = 1'b0;
    logic           model_busy = 1'b0;

    logic [8:0]  rq [N][$];
    logic [11:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    assign tx_done = model_done | spur_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N            (N),
        .MAX_BURST    (MAX_BURST),
        .HOLD_TIMEOUT (HOLD_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_byte  (req_byte),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_done   (tx_done),
        .busy      (busy)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int req, input logic [7:0] b, input logic last);
        rq[req].push_back({last, b});
    endtask

    task automatic expect_tx(input int req, input logic [7:0] b);
        exp_q.push_back({4'(1 << req), b});
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy && !model_busy && exp_q.size() == 0 && req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        check_output({name, "_idle"}, 32'(ok), 32'd1);
        check_output({name, "_grant_clear"}, 32'(grant), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 100 && model_busy; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Requesters: present queue head; pop after the edge that ends LOAD.
    initial begin
        logic [N-1:0] take;
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            take = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (take[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_byte[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_byte[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // uart_tx2 model: DONE pulse 10 bit-times after TX_DV.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                model_busy = 1'b1;
                repeat (10 * BIT_CLKS) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        logic        dv_pending;
        logic [11:0] e;
        dv_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_done) dv_pending = 1'b0;
            if (req_ready != '0) check_output("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            if (tx_dv) begin
                check_output("dv_without_done", 32'(dv_pending), 32'd0);
                dv_pending = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_tx_dv actual byte=0x%0h grant=%b expected none", tx_byte, grant);
                end else begin
                    e = exp_q.pop_front();
                    check_output("tx_byte", 32'(tx_byte), 32'(e[7:0]));
                    check_output("grant_at_dv", 32'(grant), 32'(e[11:8]));
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_tx_dv", 32'(tx_dv), 32'd0);
        check_output("rst_tx_byte", 32'(tx_byte), 32'd0);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] test 1: single message AB\\n");
        expect_tx(0, 8'h41);
        expect_tx(0, 8'h42);
        expect_tx(0, ASCII_NL);
        apply_stimulus(0, 8'h41, 1'b0);
        apply_stimulus(0, 8'h42, 1'b0);
        apply_stimulus(0, ASCII_NL, 1'b1);
        for (int k = 0; k < 10 && !req_valid[0]; k++) @(negedge clk);
        cnt = 0;
        while (!tx_dv && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check_output("t1_latency", 32'(cnt), 32'd2);
        wait_idle("t1", 400);

        $display("[TB] test 2: round robin with wrap");
        do_reset();
        expect_tx(0, 8'h30);
        expect_tx(1, 8'h31);
        expect_tx(2, 8'h32);
        expect_tx(3, 8'h33);
        expect_tx(1, 8'h35);
        apply_stimulus(0, 8'h30, 1'b1);
        apply_stimulus(1, 8'h31, 1'b1);
        apply_stimulus(1, 8'h35, 1'b1);
        apply_stimulus(2, 8'h32, 1'b1);
        apply_stimulus(3, 8'h33, 1'b1);
        wait_idle("t2", 800);

        $display("[TB] test 3: burst limit");
        do_reset();
        for (int b = 0; b < 4; b++) expect_tx(2, 8'(8'h20 + b));
        expect_tx(0, 8'h58);
        for (int b = 4; b < 10; b++) expect_tx(2, 8'(8'h20 + b));
        for (int b = 0; b < 10; b++) apply_stimulus(2, 8'(8'h20 + b), 1'b0);
        for (int k = 0; k < 20 && grant != 4'b0100; k++) @(negedge clk);
        check_output("t3_first_grant", 32'(grant), 32'h4);
        apply_stimulus(0, 8'h58, 1'b1);
        wait_idle("t3", 1500);

        $display("[TB] test 4: hold timeout");
        do_reset();
        expect_tx(1, 8'h55);
        expect_tx(3, 8'h66);
        apply_stimulus(1, 8'h55, 1'b0);
        for (int k = 0; k < 20 && grant != 4'b0010; k++) @(negedge clk);
        check_output("t4_first_grant", 32'(grant), 32'h2);
        apply_stimulus(3, 8'h66, 1'b1);
        for (int k = 0; k < 100 && !tx_done; k++) @(negedge clk);
        check_output("t4_done_seen", 32'(tx_done), 32'd1);
        cnt = 0;
        while (grant == 4'b0010 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_output("t4_release_cycles", 32'(cnt), 32'd17);
        @(negedge clk);
        check_output("t4_next_grant", 32'(grant), 32'h8);
        wait_idle("t4", 400);

        $display("[TB] test 5: spurious done");
        do_reset();
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check_output("t5_idle_busy", 32'(busy), 32'd0);
        check_output("t5_idle_dv", 32'(tx_dv), 32'd0);
        expect_tx(0, 8'h77);
        apply_stimulus(0, 8'h77, 1'b1);
        for (int k = 0; k < 20 && !req_ready[0]; k++) @(negedge clk);
        check_output("t5_load_seen", 32'(req_ready), 32'h1);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check_output("t5_dv_after_load", 32'(tx_dv), 32'd1);
        repeat (5) @(negedge clk);
        check_output("t5_still_busy", 32'(busy), 32'd1);
        check_output("t5_still_grant", 32'(grant), 32'h1);
        wait_idle("t5", 400);

        $display("[TB] test 6: reset mid-wait");
        do_reset();
        expect_tx(2, 8'h31);
        apply_stimulus(2, 8'h31, 1'b1);
        wait_idle("t6a", 400);
        expect_tx(2, 8'h32);
        apply_stimulus(2, 8'h32, 1'b1);
        for (int k = 0; k < 20 && !tx_dv; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_output("t6_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_grant", 32'(grant), 32'd0);
        check_output("t6_rst_busy", 32'(busy), 32'd0);
        check_output("t6_rst_tx_byte", 32'(tx_byte), 32'd0);
        check_output("t6_rst_ready", 32'(req_ready), 32'd0);
        expect_tx(1, 8'h99);
        expect_tx(3, 8'hAA);
        apply_stimulus(1, 8'h99, 1'b1);
        apply_stimulus(3, 8'hAA, 1'b1);
        for (int k = 0; k < 100 && model_busy; k++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t6b", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
